// File: rtl/keyword_debouncer_pkg.sv
// Shared constants and FSM state type for the keyword debouncer.
package keyword_debouncer_pkg;

  localparam int KD_KEYWORD_WIDTH          = 4;
  localparam int KD_SILENCE_CODE           = 0;
  localparam int KD_DEFAULT_CONFIRM_COUNT  = 3;
  localparam int KD_DEFAULT_HOLDOFF_FRAMES = 4;
  localparam int KD_DEFAULT_DROP_WIDTH     = 8;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COUNTING = 2'd1,
    ST_HOLDOFF  = 2'd2
  } kd_state_e;

endpackage

// File: rtl/keyword_output_reg.sv
// One-entry valid/ready holding register for confirmed keywords. A load that
// arrives while the entry is full and not being drained is discarded and
// counted in a saturating drop counter.
module keyword_output_reg #(
  parameter int KEYWORD_WIDTH = 4,
  parameter int DROP_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic [KEYWORD_WIDTH-1:0] load_keyword,
  input  logic                     det_ready,
  output logic                     det_valid,
  output logic [KEYWORD_WIDTH-1:0] det_keyword,
  output logic [DROP_WIDTH-1:0]    drop_count
);

  logic handoff;
  logic can_load;

  assign handoff  = det_valid && det_ready;
  // A draining entry frees its slot on the same edge, so a load then is not a drop.
  assign can_load = !det_valid || det_ready;

  // Entry register: load on fire when there is room, clear on handoff.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      det_valid   <= 1'b0;
      det_keyword <= '0;
    end else if (load && can_load) begin
      det_valid   <= 1'b1;
      det_keyword <= load_keyword;
    end else if (handoff) begin
      det_valid   <= 1'b0;
    end
  end

  // Saturating count of detections lost to backpressure.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_count <= '0;
    end else if (load && !can_load && (drop_count != {DROP_WIDTH{1'b1}})) begin
      drop_count <= drop_count + DROP_WIDTH'(1);
    end
  end

endmodule

// File: rtl/keyword_debouncer.sv
// Keyword debouncer: confirms a keyword after CONFIRM_COUNT consecutive
// identical non-silence frames, then ignores HOLDOFF_FRAMES accepted frames.
//
//   state       | meaning
//   ------------+-----------------------------------------------------------
//   ST_IDLE     | no run in progress; next non-silence frame starts a run
//   ST_COUNTING | run of last_kw in progress, run_cnt frames long
//   ST_HOLDOFF  | refractory period after a detection; hold_cnt frames left
module keyword_debouncer
  import keyword_debouncer_pkg::*;
#(
  parameter int KEYWORD_WIDTH  = KD_KEYWORD_WIDTH,
  parameter int SILENCE_CODE   = KD_SILENCE_CODE,
  parameter int CONFIRM_COUNT  = KD_DEFAULT_CONFIRM_COUNT,
  parameter int HOLDOFF_FRAMES = KD_DEFAULT_HOLDOFF_FRAMES,
  parameter int DROP_WIDTH     = KD_DEFAULT_DROP_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     kw_valid,
  output logic                     kw_ready,
  input  logic [KEYWORD_WIDTH-1:0] kw_in,
  output logic                     det_valid,
  input  logic                     det_ready,
  output logic [KEYWORD_WIDTH-1:0] det_keyword,
  output logic [DROP_WIDTH-1:0]    drop_count
);

  localparam int RUN_W  = $clog2(CONFIRM_COUNT + 1);
  // A zero holdoff still needs a one-bit counter so the declaration stays legal.
  localparam int HOLD_W = (HOLDOFF_FRAMES > 0) ? $clog2(HOLDOFF_FRAMES + 1) : 1;

  localparam logic [RUN_W-1:0]         CONFIRM_VAL = RUN_W'(CONFIRM_COUNT);
  localparam logic [HOLD_W-1:0]        HOLD_VAL    = HOLD_W'(HOLDOFF_FRAMES);
  localparam logic [KEYWORD_WIDTH-1:0] SILENCE_VAL = KEYWORD_WIDTH'(SILENCE_CODE);

  kd_state_e                state_q,   state_n;
  logic [RUN_W-1:0]         run_cnt_q, run_cnt_n;
  logic [KEYWORD_WIDTH-1:0] last_kw_q, last_kw_n;
  logic [HOLD_W-1:0]        hold_cnt_q, hold_cnt_n;
  logic [RUN_W-1:0]         run_upd;
  logic                     accept;
  logic                     fire;

  // The block never stalls upstream; ready simply tracks reset release.
  assign kw_ready = rst;
  assign accept   = kw_valid && kw_ready;

  // FSM and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      run_cnt_q  <= '0;
      last_kw_q  <= '0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_n;
      run_cnt_q  <= run_cnt_n;
      last_kw_q  <= last_kw_n;
      hold_cnt_q <= hold_cnt_n;
    end
  end

  // Next-state logic; everything advances only on accepted frames.
  always_comb begin
    state_n    = state_q;
    run_cnt_n  = run_cnt_q;
    last_kw_n  = last_kw_q;
    hold_cnt_n = hold_cnt_q;
    run_upd    = run_cnt_q;
    fire       = 1'b0;

    if (accept) begin
      unique case (state_q)
        ST_IDLE, ST_COUNTING: begin
          if (kw_in == SILENCE_VAL) begin
            run_cnt_n = '0;
            state_n   = ST_IDLE;
          end else begin
            if ((state_q == ST_COUNTING) && (kw_in == last_kw_q)) begin
              run_upd = run_cnt_q + RUN_W'(1);
            end else begin
              last_kw_n = kw_in;
              run_upd   = RUN_W'(1);
            end
            state_n   = ST_COUNTING;
            run_cnt_n = run_upd;
            if (run_upd == CONFIRM_VAL) begin
              fire       = 1'b1;
              run_cnt_n  = '0;
              hold_cnt_n = HOLD_VAL;
              state_n    = (HOLDOFF_FRAMES > 0) ? ST_HOLDOFF : ST_IDLE;
            end
          end
        end
        ST_HOLDOFF: begin
          if (hold_cnt_q != '0) begin
            hold_cnt_n = hold_cnt_q - HOLD_W'(1);
          end
          if (hold_cnt_q <= HOLD_W'(1)) begin
            state_n = ST_IDLE;
          end
        end
        default: begin
          state_n   = ST_IDLE;
          run_cnt_n = '0;
        end
      endcase
    end
  end

  // The firing frame's keyword is the confirmed keyword.
  keyword_output_reg #(
    .KEYWORD_WIDTH (KEYWORD_WIDTH),
    .DROP_WIDTH    (DROP_WIDTH)
  ) u_output_reg (
    .clk          (clk),
    .rst          (rst),
    .load         (fire),
    .load_keyword (kw_in),
    .det_ready    (det_ready),
    .det_valid    (det_valid),
    .det_keyword  (det_keyword),
    .drop_count   (drop_count)
  );

endmodule

// File: tb/tb_keyword_debouncer.sv
// Self-checking bench for keyword_debouncer: directed scenarios plus random
// traffic, compared every cycle against a frame-history reference model.
module tb_keyword_debouncer;

  localparam int CONFIRM  = 3;
  localparam int HOLDOFF  = 4;
  localparam int DROP_MAX = 255;
  localparam logic [3:0] SILENCE = 4'd0;

  logic       clk;
  logic       rst;
  logic       kw_valid;
  logic       kw_ready;
  logic [3:0] kw_in;
  logic       det_valid;
  logic       det_ready;
  logic [3:0] det_keyword;
  logic [7:0] drop_count;

  int n_tests;
  int n_fail;

  // Reference model state
  logic [3:0] hist[$];
  int         ign_left;
  bit         m_valid;
  logic [3:0] m_kw;
  int         m_drop;
  int         dut_handoffs;
  logic [3:0] handed[$];

  keyword_debouncer dut (
    .clk         (clk),
    .rst         (rst),
    .kw_valid    (kw_valid),
    .kw_ready    (kw_ready),
    .kw_in       (kw_in),
    .det_valid   (det_valid),
    .det_ready   (det_ready),
    .det_keyword (det_keyword),
    .drop_count  (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    hist.delete();
    ign_left = 0;
    m_valid  = 0;
    m_kw     = '0;
    m_drop   = 0;
  endtask

  task automatic check_outputs(input string tag);
    check_val({tag, ".kw_ready"},    32'(kw_ready),    32'(1));
    check_val({tag, ".det_valid"},   32'(det_valid),   32'(m_valid));
    check_val({tag, ".det_keyword"}, 32'(det_keyword), 32'(m_kw));
    check_val({tag, ".drop_count"},  32'(drop_count),  32'(m_drop));
  endtask

  // One clock: drive inputs, apply the edge, update the model, check outputs.
  task automatic step(input bit kv, input logic [3:0] kin, input bit dr, input string tag);
    bit fire;
    kw_valid  = kv;
    kw_in     = kin;
    det_ready = dr;
    if (det_valid && dr) begin
      dut_handoffs++;
      handed.push_back(det_keyword);
    end
    @(posedge clk);
    fire = 0;
    if (kv) begin
      if (ign_left > 0) begin
        ign_left--;
      end else begin
        hist.push_back(kin);
        if (hist.size() > CONFIRM) void'(hist.pop_front());
        if (hist.size() == CONFIRM && kin != SILENCE) begin
          fire = 1;
          foreach (hist[i]) if (hist[i] != kin) fire = 0;
        end
        if (fire) begin
          hist.delete();
          ign_left = HOLDOFF;
        end
      end
    end
    if (m_valid && dr) m_valid = 0;
    if (fire) begin
      if (m_valid) begin
        if (m_drop < DROP_MAX) m_drop++;
      end else begin
        m_valid = 1;
        m_kw    = kin;
      end
    end
    #1;
    check_outputs(tag);
  endtask

  // Asynchronous reset asserted mid-cycle, held a few edges, released on a negedge.
  task automatic do_reset();
    #3;
    rst = 1'b0;
    #1;
    check_val("rst.kw_ready",    32'(kw_ready),    32'(0));
    check_val("rst.det_valid",   32'(det_valid),   32'(0));
    check_val("rst.det_keyword", 32'(det_keyword), 32'(0));
    check_val("rst.drop_count",  32'(drop_count),  32'(0));
    repeat (3) begin
      kw_valid  = 1'($urandom_range(0, 1));
      kw_in     = 4'($urandom_range(0, 15));
      det_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      check_val("rst_hold.kw_ready",  32'(kw_ready),  32'(0));
      check_val("rst_hold.det_valid", 32'(det_valid), 32'(0));
    end
    @(negedge clk);
    rst      = 1'b1;
    kw_valid = 1'b0;
    model_clear();
    handed.delete();
    dut_handoffs = 0;
    #1;
    check_val("rst_release.kw_ready", 32'(kw_ready), 32'(1));
  endtask

  initial begin
    int hs;
    n_tests = 0;
    n_fail  = 0;
    dut_handoffs = 0;
    rst       = 1'b0;
    kw_valid  = 1'b0;
    kw_in     = '0;
    det_ready = 1'b0;
    model_clear();
    do_reset();

    // Basic: 5,5,5 detects once with latency 1
    step(1, 4'd5, 1, "b555");
    step(1, 4'd5, 1, "b555");
    step(1, 4'd5, 1, "b555");
    check_val("b555.fire_valid", 32'(det_valid), 32'(1));
    check_val("b555.fire_kw", 32'(det_keyword), 32'(5));
    step(0, 4'd0, 1, "b555_drain");
    check_val("b555.one_cycle", 32'(det_valid), 32'(0));

    // 5,5,7,7,7 -> one detection of 7
    do_reset();
    foreach (handed[i]) handed.delete(i);
    step(1, 4'd5, 1, "b57"); step(1, 4'd5, 1, "b57");
    step(1, 4'd7, 1, "b57"); step(1, 4'd7, 1, "b57"); step(1, 4'd7, 1, "b57");
    step(0, 4'd0, 1, "b57"); step(0, 4'd0, 1, "b57");
    check_val("b57.count", 32'(dut_handoffs), 32'(1));
    hs = handed.size();
    if (hs > 0) check_val("b57.kw", 32'(handed[0]), 32'(7));
    else        check_val("b57.kw_missing", 32'(hs), 32'(1));

    // 5,5,0,5,5 -> nothing
    do_reset();
    step(1, 4'd5, 1, "b50"); step(1, 4'd5, 1, "b50"); step(1, 4'd0, 1, "b50");
    step(1, 4'd5, 1, "b50"); step(1, 4'd5, 1, "b50"); step(0, 4'd0, 1, "b50");
    check_val("b50.count", 32'(dut_handoffs), 32'(0));

    // Holdoff: ten frames of 5 -> detections after frames 3 and 10
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      step(1, 4'd5, 1, "hold");
      if (i == 3 || i == 10) check_val("hold.fire", 32'(det_valid), 32'(1));
      else                   check_val("hold.quiet", 32'(det_valid), 32'(0));
    end
    step(0, 4'd0, 1, "hold"); step(0, 4'd0, 1, "hold");
    check_val("hold.count", 32'(dut_handoffs), 32'(2));

    // Backpressure drop
    do_reset();
    step(1, 4'd3, 0, "bp"); step(1, 4'd3, 0, "bp"); step(1, 4'd3, 0, "bp");
    repeat (HOLDOFF) step(1, 4'd1, 0, "bp");
    step(1, 4'd9, 0, "bp"); step(1, 4'd9, 0, "bp"); step(1, 4'd9, 0, "bp");
    check_val("bp.held_kw", 32'(det_keyword), 32'(3));
    check_val("bp.drop", 32'(drop_count), 32'(1));
    step(0, 4'd0, 1, "bp_hand");
    check_val("bp.handed", 32'(handed.size() > 0 ? handed[0] : 4'hF), 32'(3));
    repeat (HOLDOFF) step(1, 4'd1, 1, "bp2");
    step(1, 4'd9, 1, "bp2"); step(1, 4'd9, 1, "bp2"); step(1, 4'd9, 1, "bp2");
    check_val("bp2.kw", 32'(det_keyword), 32'(9));
    check_val("bp2.valid", 32'(det_valid), 32'(1));

    // Simultaneous handoff and fire
    do_reset();
    step(1, 4'd3, 0, "sim"); step(1, 4'd3, 0, "sim"); step(1, 4'd3, 0, "sim");
    repeat (HOLDOFF) step(1, 4'd1, 0, "sim");
    step(1, 4'd9, 0, "sim"); step(1, 4'd9, 0, "sim");
    step(1, 4'd9, 1, "sim_fire");
    check_val("sim.valid_cont", 32'(det_valid), 32'(1));
    check_val("sim.new_kw", 32'(det_keyword), 32'(9));
    check_val("sim.drop", 32'(drop_count), 32'(0));
    check_val("sim.handed3", 32'(handed.size() > 0 ? handed[0] : 4'hF), 32'(3));

    // Reset mid-run
    do_reset();
    step(1, 4'd6, 1, "rmid"); step(1, 4'd6, 1, "rmid");
    do_reset();
    step(1, 4'd6, 1, "rmid2");
    step(1, 4'd6, 1, "rmid2");
    check_val("rmid.no_early", 32'(det_valid), 32'(0));
    step(1, 4'd6, 1, "rmid2");
    check_val("rmid.third", 32'(det_valid), 32'(1));

    // Reset during holdoff
    step(0, 4'd0, 1, "rhold");
    step(1, 4'd5, 1, "rhold");
    do_reset();
    step(1, 4'd7, 1, "rhold2"); step(1, 4'd7, 1, "rhold2"); step(1, 4'd7, 1, "rhold2");
    check_val("rhold.det", 32'(det_valid), 32'(1));
    check_val("rhold.kw", 32'(det_keyword), 32'(7));

    // Random traffic over a small alphabet so runs actually form
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      logic [3:0] k;
      int sel;
      sel = $urandom_range(0, 9);
      k = (sel < 2) ? 4'd0 : (sel < 7) ? 4'd5 : (sel < 9) ? 4'd7 : 4'($urandom_range(1, 15));
      step(($urandom_range(0, 3) != 0), k, ($urandom_range(0, 9) < 7), "rand");
    end

    // Drop counter saturation under permanent backpressure
    do_reset();
    for (int i = 0; i < 2100; i++) step(1, 4'd5, 0, "sat");
    check_val("sat.drop", 32'(drop_count), 32'(DROP_MAX));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
